// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage RV32I pipeline.
// Issues loads/stores on a req/ack data bus, places store byte lanes, extracts and extends
// load data, and asks ctrl to stall while an access is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that sees no ack for
// TIMEOUT_CYCLES cycles (bus_err_o pulses, no register write).
module mem_access #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RADDR_WIDTH    = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_we_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [3:0]             mem_op_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
    input  logic                   dbus_ack_i,
    input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
    output logic                   stall_req_o,
    output logic                   misalign_o,
    output logic                   bus_err_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o
);
    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLw  = 4'd3;
    localparam logic [3:0] OpLbu = 4'd4;
    localparam logic [3:0] OpLhu = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [1:0]            off;
    logic                  is_load, is_store, misalign, access, timed_out;
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wdata_c, word, load_val;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign off = mem_addr_i[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] cnt_q;
    logic            err_q;
    logic            timeout_hit;
    // Last allowed WAIT cycle passed without an ack
    assign timeout_hit = (state_q == StWait) && !dbus_ack_i &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign timed_out   = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    // Decode op into access class, alignment check and store lane placement
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        be_c     = 4'b1111;
        wdata_c  = mem_data_i;
        case (mem_op_i)
            OpLb, OpLbu: is_load = 1'b1;
            OpLh, OpLhu: begin
                is_load  = 1'b1;
                misalign = off[0];
            end
            OpLw: begin
                is_load  = 1'b1;
                misalign = (off != 2'b00);
            end
            OpSb: begin
                is_store = 1'b1;
                be_c     = 4'b0001 << off;
                wdata_c  = {4{mem_data_i[7:0]}};
            end
            OpSh: begin
                is_store = 1'b1;
                misalign = off[0];
                be_c     = off[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{mem_data_i[15:0]}};
            end
            OpSw: begin
                is_store = 1'b1;
                misalign = (off != 2'b00);
            end
            default: ;
        endcase
        access = (is_load || is_store) && !misalign;
    end

    // Load extraction: DONE replays the captured word, otherwise the live bus word
    always_comb begin
        word     = (state_q == StDone) ? rdata_q : dbus_rdata_i;
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (mem_op_i)
            OpLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_val = {24'd0, byte_sel};
            OpLh:    load_val = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    // FSM, captured read word and optional WAIT timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (access && !dbus_ack_i) state_q <= StWait;
                end
                StWait: begin
                    if (dbus_ack_i) begin
                        rdata_q <= dbus_rdata_i;
                        state_q <= StDone;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    // Held instruction is retired here, never reissued
                    state_q <= StIdle;
`ifdef MEM_TIMEOUT_EN
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus, stall and writeback outputs; all forced to 0 while reset is asserted
    always_comb begin
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_be_o    = 4'b0000;
        dbus_wdata_o = '0;
        stall_req_o  = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        reg_waddr_o  = '0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = '0;
        if (!rst_i) begin
            case (state_q)
                StIdle: begin
                    dbus_req_o  = access;
                    stall_req_o = access && !dbus_ack_i;
                    misalign_o  = misalign;
                end
                StWait: begin
                    dbus_req_o  = 1'b1;
                    stall_req_o = 1'b1;
                end
                default: ;
            endcase
            bus_err_o    = (state_q == StDone) && timed_out;
            dbus_we_o    = dbus_req_o && mem_we_i;
            dbus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            dbus_be_o    = dbus_req_o ? be_c : 4'b0000;
            dbus_wdata_o = wdata_c;
            reg_waddr_o  = reg_waddr_i;
            reg_we_o     = reg_we_i && !misalign_o && !bus_err_o;
            reg_wdata_o  = (is_load && !misalign) ? load_val : reg_wdata_i;
        end
    end

endmodule
